// File: rtl/led_blink_pkg.sv
// Shared definitions for the multi-channel LED blinker: mode codes, burst
// FSM states and the rate-to-half-period helper.
package led_blink_pkg;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_SOLID = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RUN
  } burst_state_t;

  function automatic int unsigned half_period(input int unsigned clk_hz,
                                              input int unsigned rate_hz);
    return clk_hz / (2 * rate_hz);
  endfunction

endpackage

// File: rtl/rate_toggle.sv
// Square-wave rate generator: phase toggles every HALF clocks. o_rise/o_fall
// flag the edge on which the phase is about to change.
module rate_toggle #(
  parameter int unsigned HALF = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_phase,
  output logic o_rise,
  output logic o_fall
);
  localparam int unsigned CW = $clog2(HALF);

  logic [CW-1:0] r_cnt;
  logic          r_phase;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(HALF - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_wrap) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  assign o_phase = r_phase;
  assign o_rise  = w_wrap & ~r_phase;
  assign o_fall  = w_wrap &  r_phase;

endmodule

// File: rtl/multi_led_blinker.sv
// NUM_CH LED channels sharing four rate generators and one PWM counter; each
// channel selects off/solid/blink/burst and drives a registered LED output.
module multi_led_blinker
  import led_blink_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 25_000_000,
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned RATE0_HZ = 100,
  parameter int unsigned RATE1_HZ = 50,
  parameter int unsigned RATE2_HZ = 10,
  parameter int unsigned RATE3_HZ = 1,
  parameter int unsigned BRIGHT_W = 4,
  parameter int unsigned BURST_N  = 3
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [2*NUM_CH-1:0]          i_mode,
  input  logic [2*NUM_CH-1:0]          i_rate_sel,
  input  logic [BRIGHT_W*NUM_CH-1:0]   i_bright,
  input  logic [NUM_CH-1:0]            i_trig,
  output logic [NUM_CH-1:0]            o_led,
  output logic [NUM_CH-1:0]            o_busy
);
  localparam int unsigned RATE_HZ [4] = '{RATE0_HZ, RATE1_HZ, RATE2_HZ, RATE3_HZ};

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("multi_led_blinker: NUM_CH must be in 1..16");
  end
  if (BURST_N < 1 || BURST_N > 255) begin : g_bad_burst_n
    $error("multi_led_blinker: BURST_N must be in 1..255");
  end

  logic [3:0] w_phase;
  logic [3:0] w_rise;
  logic [3:0] w_fall;

  for (genvar k = 0; k < 4; k++) begin : g_rate
    localparam int unsigned HALF_K = half_period(CLK_HZ, RATE_HZ[k]);
    if ((CLK_HZ % (2 * RATE_HZ[k])) != 0 || HALF_K < 2) begin : g_bad_rate
      $error("multi_led_blinker: rate %0d does not give an integral half period >= 2", k);
    end
    rate_toggle #(.HALF(HALF_K)) u_rate (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .o_phase (w_phase[k]),
      .o_rise  (w_rise[k]),
      .o_fall  (w_fall[k])
    );
  end

  logic [BRIGHT_W-1:0] r_pwm_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_pwm_cnt <= '0;
    else         r_pwm_cnt <= r_pwm_cnt + BRIGHT_W'(1);
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [1:0]          w_mode;
    logic [1:0]          w_sel;
    logic [BRIGHT_W-1:0] w_bright;
    burst_state_t        r_state, w_state_nx;
    logic [1:0]          r_sel, w_sel_nx;
    logic [7:0]          r_cnt, w_cnt_nx;
    logic                w_raw;
    logic                r_led;

    assign w_mode   = i_mode[2*ch +: 2];
    assign w_sel    = i_rate_sel[2*ch +: 2];
    assign w_bright = i_bright[BRIGHT_W*ch +: BRIGHT_W];

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        r_state <= IDLE;
        r_sel   <= '0;
        r_cnt   <= '0;
        r_led   <= 1'b0;
      end else begin
        r_state <= w_state_nx;
        r_sel   <= w_sel_nx;
        r_cnt   <= w_cnt_nx;
        r_led   <= w_raw & (r_pwm_cnt <= w_bright);
      end
    end

    // Bursts start on a rising edge and end on a falling edge of the latched
    // rate, so every emitted pulse is a full half period high and low.
    always_comb begin
      w_state_nx = r_state;
      w_sel_nx   = r_sel;
      w_cnt_nx   = r_cnt;
      case (r_state)
        IDLE: begin
          if (w_mode == MODE_BURST && i_trig[ch]) begin
            w_state_nx = WAIT;
            w_sel_nx   = w_sel;
            w_cnt_nx   = '0;
          end
        end
        WAIT: begin
          if (w_mode != MODE_BURST) w_state_nx = IDLE;
          else if (w_rise[r_sel])   w_state_nx = RUN;
        end
        RUN: begin
          if (w_mode != MODE_BURST) begin
            w_state_nx = IDLE;
          end else if (w_fall[r_sel]) begin
            if (r_cnt == 8'(BURST_N - 1)) w_state_nx = IDLE;
            else                          w_cnt_nx   = r_cnt + 8'd1;
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end

    always_comb begin
      w_raw = 1'b0;
      case (w_mode)
        MODE_OFF:   w_raw = 1'b0;
        MODE_SOLID: w_raw = 1'b1;
        MODE_BLINK: w_raw = w_phase[w_sel];
        MODE_BURST: w_raw = (r_state == RUN) & w_phase[r_sel];
        default:    w_raw = 1'b0;
      endcase
    end

    assign o_led[ch]  = r_led;
    assign o_busy[ch] = (r_state != IDLE);
  end

endmodule

// File: tb/tb_multi_led_blinker.sv
// Self-checking bench for multi_led_blinker with an arithmetic reference model
// (phase = floor(n/HALF) mod 2, PWM = n mod 16, bursts as precomputed windows).
module tb_multi_led_blinker;
  localparam int NCH = 4;
  localparam int BW  = 4;
  localparam int BN  = 3;
  localparam int HALF [4] = '{1000/200, 1000/100, 1000/20, 1000/2};

  logic              clk = 1'b0;
  logic              rst;
  logic [2*NCH-1:0]  mode, sel;
  logic [BW*NCH-1:0] bright;
  logic [NCH-1:0]    trig, led, busy;

  int errors = 0;
  int checks = 0;

  // model state: n = clock edges since the last reset edge
  int n;
  bit act   [NCH];
  int b_h   [NCH];
  int b_r   [NCH];
  int b_end [NCH];
  logic [NCH-1:0] exp_led, exp_busy;

  always #5 clk = ~clk;

  multi_led_blinker #(
    .CLK_HZ   (1000),
    .NUM_CH   (NCH),
    .RATE0_HZ (100),
    .RATE1_HZ (50),
    .RATE2_HZ (10),
    .RATE3_HZ (1),
    .BRIGHT_W (BW),
    .BURST_N  (BN)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_mode     (mode),
    .i_rate_sel (sel),
    .i_bright   (bright),
    .i_trig     (trig),
    .o_led      (led),
    .o_busy     (busy)
  );

  function automatic bit ph(input int m, input int h);
    return ((m / h) % 2) == 1;
  endfunction

  // Predicts the outputs after the next edge from the current inputs, then clocks.
  task automatic tick();
    logic [NCH-1:0] nl, nb;
    nl = '0;
    nb = '0;
    if (rst) begin
      n = 0;
      for (int c = 0; c < NCH; c++) act[c] = 0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        int m, s, b, h, e;
        bit raw;
        m = int'(mode[2*c +: 2]);
        s = int'(sel[2*c +: 2]);
        b = int'(bright[BW*c +: BW]);
        case (m)
          0:       raw = 0;
          1:       raw = 1;
          2:       raw = ph(n, HALF[s]);
          default: raw = act[c] && n >= b_r[c] && ph(n, b_h[c]);
        endcase
        nl[c] = raw && ((n % (1 << BW)) <= b);
        if (act[c]) begin
          if (m != 3 || n + 1 == b_end[c]) act[c] = 0;
        end else if (m == 3 && trig[c]) begin
          h = HALF[s];
          e = n + 2;
          act[c] = 1;
          b_h[c] = h;
          b_r[c] = (e <= h) ? h : h + 2*h*((e - h + 2*h - 1) / (2*h));
          b_end[c] = b_r[c] + (2*BN - 1)*h;
        end
        nb[c] = act[c];
      end
      n++;
    end
    @(posedge clk);
    #1;
    exp_led  = nl;
    exp_busy = nb;
  endtask

  task automatic set_ch(input int c, input logic [1:0] m, input logic [1:0] s,
                        input logic [BW-1:0] b);
    mode[2*c +: 2]    = m;
    sel[2*c +: 2]     = s;
    bright[BW*c +: BW] = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mode = $urandom; sel = $urandom; bright = $urandom; trig = '1;
    repeat (3) tick();
    if (led !== '0) begin errors++; $display("FAIL reset_led got=%b exp=0", led); end
    checks++;
    if (busy !== '0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
  endtask

  task automatic test_blink_start();
    int first;
    first = -1;
    rst = 1'b1; mode = '0; sel = '0; bright = '1; trig = '0;
    set_ch(0, 2'b10, 2'd0, 4'd15);
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (led !== exp_led) begin errors++; $display("FAIL blink_led n=%0d got=%b exp=%b", n, led, exp_led); end
      checks++;
      if (first < 0 && led[0] === 1'b1) first = i;
    end
    if (first != 6) begin errors++; $display("FAIL blink_first_rise got=%0d exp=6", first); end
    checks++;
  endtask

  task automatic test_pwm();
    int codes [4];
    codes = '{3, 0, 15, int'($urandom_range(0, 15))};
    for (int k = 0; k < 4; k++) begin
      int cnt;
      cnt = 0;
      set_ch(1, 2'b01, 2'd0, 4'(codes[k]));
      for (int i = 0; i < 16; i++) begin
        tick();
        if (led !== exp_led) begin errors++; $display("FAIL pwm_led n=%0d got=%b exp=%b", n, led, exp_led); end
        checks++;
        if (led[1] === 1'b1) cnt++;
      end
      if (cnt != codes[k] + 1) begin
        errors++; $display("FAIL pwm_duty code=%0d got=%0d exp=%0d", codes[k], cnt, codes[k] + 1);
      end
      checks++;
    end
    set_ch(1, 2'b00, 2'd0, 4'd0);
  endtask

  task automatic test_burst(input bit retrig);
    int rises, run, tail;
    bit prev, done, retrig_done;
    rises = 0; run = 0; tail = 0; prev = 0; done = 0; retrig_done = 0;
    set_ch(2, 2'b11, 2'd1, 4'd15);
    trig[2] = 1'b1;
    tick();
    trig[2] = 1'b0;
    if (busy[2] !== 1'b1) begin errors++; $display("FAIL burst_busy_set got=%b exp=1", busy[2]); end
    checks++;
    for (int i = 0; i < 400 && tail < 4; i++) begin
      if (retrig && !retrig_done && rises == 1 && prev) begin
        trig[2] = 1'b1;
        retrig_done = 1;
      end
      tick();
      trig[2] = 1'b0;
      if (led !== exp_led || busy !== exp_busy) begin
        errors++; $display("FAIL burst_model n=%0d led=%b/%b busy=%b/%b", n, led, exp_led, busy, exp_busy);
      end
      checks++;
      run++;
      if (led[2] !== prev) begin
        if (prev) begin
          if (run != 10) begin errors++; $display("FAIL burst_high_width got=%0d exp=10", run); end
          checks++;
        end else begin
          if (rises > 0) begin
            if (run != 10) begin errors++; $display("FAIL burst_low_width got=%0d exp=10", run); end
            checks++;
          end
          rises++;
        end
        prev = led[2];
        run = 0;
      end
      if (busy[2] === 1'b0) begin done = 1; tail++; end
    end
    if (!done) begin errors++; $display("FAIL burst_end got=busy exp=idle"); end
    checks++;
    if (rises != BN) begin errors++; $display("FAIL burst_pulses retrig=%0d got=%0d exp=%0d", retrig, rises, BN); end
    checks++;
    set_ch(2, 2'b00, 2'd0, 4'd0);
  endtask

  task automatic test_abort();
    int i;
    set_ch(3, 2'b11, 2'd0, 4'd15);
    trig[3] = 1'b1;
    tick();
    trig[3] = 1'b0;
    i = 0;
    while (led[3] !== 1'b1 && i < 100) begin tick(); i++; end
    if (led[3] !== 1'b1) begin errors++; $display("FAIL abort_run_reached got=%b exp=1", led[3]); end
    checks++;
    sel[2*3 +: 2] = 2'd3;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (led !== exp_led || busy !== exp_busy) begin
        errors++; $display("FAIL abort_selchg n=%0d led=%b/%b busy=%b/%b", n, led, exp_led, busy, exp_busy);
      end
      checks++;
    end
    if (busy[3] !== 1'b1) begin errors++; $display("FAIL abort_busy_before got=%b exp=1", busy[3]); end
    checks++;
    mode[2*3 +: 2] = 2'b10;
    tick();
    if (busy[3] !== 1'b0) begin errors++; $display("FAIL abort_busy_after got=%b exp=0", busy[3]); end
    checks++;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (led !== exp_led || busy !== exp_busy) begin
        errors++; $display("FAIL abort_follow n=%0d led=%b/%b busy=%b/%b", n, led, exp_led, busy, exp_busy);
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid();
    int i, first;
    for (int c = 0; c < NCH; c++) set_ch(c, 2'b11, 2'd0, 4'd15);
    trig = '1;
    tick();
    trig = '0;
    i = 0;
    while (led === '0 && i < 60) begin tick(); i++; end
    if (busy !== '1) begin errors++; $display("FAIL rstmid_busy_before got=%b exp=1111", busy); end
    checks++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if (led !== '0) begin errors++; $display("FAIL rstmid_led got=%b exp=0", led); end
    checks++;
    if (busy !== '0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++;
    for (int c = 0; c < NCH; c++) set_ch(c, 2'b10, 2'd0, 4'd15);
    first = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (led !== exp_led) begin errors++; $display("FAIL rstmid_model n=%0d got=%b exp=%b", n, led, exp_led); end
      checks++;
      if (first < 0 && led[0] === 1'b1) first = k;
    end
    if (first != 6) begin errors++; $display("FAIL rstmid_phase_restart got=%0d exp=6", first); end
    checks++;
  endtask

  task automatic test_periods();
    int rises [NCH];
    int t_rise [NCH][3];
    logic [NCH-1:0] prev;
    rst = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      set_ch(c, 2'b10, 2'(c), 4'd15);
      rises[c] = 0;
    end
    tick();
    rst = 1'b0;
    prev = led;
    for (int i = 0; i < 3200; i++) begin
      tick();
      if (led !== exp_led) begin errors++; $display("FAIL period_model n=%0d got=%b exp=%b", n, led, exp_led); end
      checks++;
      for (int c = 0; c < NCH; c++)
        if (led[c] === 1'b1 && prev[c] === 1'b0 && rises[c] < 3) begin
          t_rise[c][rises[c]] = i;
          rises[c]++;
        end
      prev = led;
    end
    for (int c = 0; c < NCH; c++) begin
      if (rises[c] < 3) begin
        errors++; $display("FAIL period_rises ch=%0d got=%0d exp=3", c, rises[c]);
      end else begin
        for (int p = 0; p < 2; p++)
          if (t_rise[c][p+1] - t_rise[c][p] != 2*HALF[c]) begin
            errors++;
            $display("FAIL period ch=%0d got=%0d exp=%0d", c, t_rise[c][p+1] - t_rise[c][p], 2*HALF[c]);
          end
      end
      checks++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        int c, m;
        c = int'($urandom_range(0, NCH - 1));
        m = int'($urandom_range(0, 5));
        set_ch(c, 2'((m > 3) ? 3 : m), 2'($urandom_range(0, 2)), 4'($urandom));
      end
      trig = NCH'($urandom & $urandom);
      rst  = ($urandom_range(0, 399) == 0);
      tick();
      if (led !== exp_led || busy !== exp_busy) begin
        errors++; $display("FAIL random n=%0d led=%b/%b busy=%b/%b", n, led, exp_led, busy, exp_busy);
      end
      checks++;
    end
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; mode = '0; sel = '0; bright = '0; trig = '0;
    n = 0;
    exp_led = '0; exp_busy = '0;
    for (int c = 0; c < NCH; c++) act[c] = 0;
    #2;
    test_reset();
    test_blink_start();
    test_pwm();
    test_burst(1'b0);
    test_burst(1'b1);
    test_abort();
    test_reset_mid();
    test_periods();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
